// File: rtl/store_split_sequencer_if.sv
// Fetch/decode handshake bundle for the store split sequencer.
// The sequencer attaches through the slave modport; fetch and decode
// (or a bench standing in for them) attach through the master modport.
interface store_split_sequencer_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              out_prefix;
  logic [CNT_W-1:0]  split_cnt;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_prefix, split_cnt
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_prefix, split_cnt
  );
endinterface

// File: rtl/store_split_sequencer.sv
// One-entry fetch->decode stage that splits sb/sh into a `lw x0` prefix at
// the same effective address followed by the original store. Everything
// else passes through with one cycle of latency.
module store_split_sequencer #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  store_split_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PASS, PREFIX, STORE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [INST_W-1:0] hold_inst;
  logic              in_fire;
  logic              in_split;
  logic              load_in;
  logic              load_hold;
  logic              cnt_inc;

  // sb (funct3 000) and sh (funct3 001) stores; sw and the rest pass through
  function automatic logic is_split(input logic [INST_W-1:0] inst);
    return (inst[6:0] == 7'b0100011) && (inst[14:13] == 2'b00);
  endfunction

  // lw x0, imm(rs1): the S-immediate halves reassemble into the I-immediate
  function automatic logic [INST_W-1:0] prefix_of(input logic [INST_W-1:0] inst);
    return {inst[31:25], inst[11:7], inst[19:15], 3'b010, 5'b00000, 7'b0000011};
  endfunction

  // Counter stops at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  assign bus.out_valid  = (state != IDLE);
  assign bus.out_prefix = (state == PREFIX);
  assign in_fire        = bus.in_valid && bus.in_ready;
  assign in_split       = is_split(bus.in_inst);

  // Fetch may hand over only when the single output slot is free or draining
  always_comb begin
    bus.in_ready = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE:        bus.in_ready = 1'b1;
        PASS, STORE: bus.in_ready = bus.out_ready;
        default:     bus.in_ready = 1'b0;
      endcase
    end
  end

  // Next state and datapath load strobes; flush drops everything in flight
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    load_hold = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          load_in   = 1'b1;
          state_nxt = in_split ? PREFIX : PASS;
        end
      end
      PASS, STORE: begin
        if (bus.out_ready) begin
          cnt_inc = (state == STORE);
          if (in_fire) begin
            load_in   = 1'b1;
            state_nxt = in_split ? PREFIX : PASS;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      PREFIX: begin
        if (bus.out_ready) begin
          load_hold = 1'b1;
          state_nxt = STORE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      load_in   = 1'b0;
      load_hold = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output slot and store hold register; the prefix and store share the PC
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_inst <= '0;
      bus.out_pc   <= '0;
    end else if (load_in) begin
      bus.out_inst <= in_split ? prefix_of(bus.in_inst) : bus.in_inst;
      bus.out_pc   <= bus.in_pc;
      hold_inst    <= bus.in_inst;
    end else if (load_hold) begin
      bus.out_inst <= hold_inst;
    end
  end

  // Completed-split counter, bumped when the store half leaves
  always_ff @(posedge clk) begin
    if (rst)          bus.split_cnt <= '0;
    else if (cnt_inc) bus.split_cnt <= sat_inc(bus.split_cnt);
  end

endmodule

// File: tb/tb_store_split_sequencer.sv
// Bench for store_split_sequencer: directed scenarios plus random traffic,
// all checked against a queue-of-decode-slots model of the stage.
module tb_store_split_sequencer;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          prefix;
    bit          split_store;
  } slot_t;

  slot_t       q[$];
  int unsigned cnt_m = 0;

  store_split_sequencer_if #(.INST_W(32), .PC_W(32), .CNT_W(16)) bus ();
  store_split_sequencer_if #(.INST_W(32), .PC_W(32), .CNT_W(2))  sbus ();

  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_inst   = bus.in_inst;
  assign sbus.in_pc     = bus.in_pc;
  assign sbus.out_ready = bus.out_ready;

  store_split_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  store_split_sequencer #(.INST_W(32), .PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .bus(sbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit model_split(input logic [31:0] inst);
    return (inst[6:0] == 7'h23) && (inst[14:12] < 3'd2);
  endfunction

  function automatic logic [31:0] model_prefix(input logic [31:0] inst);
    int unsigned imm;
    int unsigned rs1;
    imm = ((inst >> 25) << 5) | ((inst >> 7) & 32'h1f);
    rs1 = (inst >> 15) & 32'h1f;
    return (imm << 20) | (rs1 << 15) | (32'd2 << 12) | 32'h03;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  // One clock: drive inputs at negedge, check, advance the model, wait past posedge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic  exp_ir;
    slot_t s;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    exp_ir = !rst && !fl && (q.size() == 0 || (q.size() == 1 && ordy));
    check("in_ready", bus.in_ready, exp_ir);
    if (!rst) begin
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("out_inst", bus.out_inst, q[0].inst);
        check("out_pc", bus.out_pc, q[0].pc);
        check("out_prefix", bus.out_prefix, q[0].prefix);
      end
      check("split_cnt", bus.split_cnt, sat(cnt_m, 65535));
      check("sat_cnt", sbus.split_cnt, sat(cnt_m, 3));
    end
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) begin
        s = q.pop_front();
        if (s.split_store) cnt_m++;
      end
      if (v && exp_ir) begin
        if (model_split(inst)) begin
          q.push_back('{model_prefix(inst), pc, 1'b1, 1'b0});
          q.push_back('{inst, pc, 1'b0, 1'b1});
        end else begin
          q.push_back('{inst, pc, 1'b0, 1'b0});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: begin x[6:0] = 7'h23; x[14:12] = 3'b000; end
      1: begin x[6:0] = 7'h23; x[14:12] = 3'b001; end
      2: begin x[6:0] = 7'h23; x[14:12] = 3'b010; end
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // reset
    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_split_cnt", bus.split_cnt, 16'h0);

    // pass-through
    step(1'b1, 32'h00100093, 32'h100, 1'b1, 1'b0);
    check("pass_addi", bus.out_inst, 32'h00100093);
    step(1'b1, 32'h00512223, 32'h104, 1'b1, 1'b0);
    check("pass_sw", bus.out_inst, 32'h00512223);
    check("pass_sw_prefix", bus.out_prefix, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pass_cnt", bus.split_cnt, 16'd0);

    // sb split
    step(1'b1, 32'h00510223, 32'h200, 1'b1, 1'b0);
    check("sb_prefix_inst", bus.out_inst, 32'h00412003);
    check("sb_prefix_flag", bus.out_prefix, 1'b1);
    check("sb_prefix_pc", bus.out_pc, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("sb_store_inst", bus.out_inst, 32'h00510223);
    check("sb_store_flag", bus.out_prefix, 1'b0);
    check("sb_store_pc", bus.out_pc, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("sb_cnt", bus.split_cnt, 16'd1);

    // sh with negative offset under backpressure
    step(1'b1, 32'hFE619E23, 32'h300, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("sh_prefix_hold", bus.out_inst, 32'hFFC1A003);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("sh_store_inst", bus.out_inst, 32'hFE619E23);
    check("sh_cnt_before", bus.split_cnt, 16'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("sh_cnt_after", bus.split_cnt, 16'd2);

    // flush during the prefix
    step(1'b1, 32'h00510223, 32'h400, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_cnt", bus.split_cnt, 16'd2);
    step(1'b1, 32'h00100093, 32'h404, 1'b1, 1'b0);
    check("flush_next_inst", bus.out_inst, 32'h00100093);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // reset while the store half is stalled
    step(1'b1, 32'h00510223, 32'h500, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_out_inst", bus.out_inst, 32'h0);
    check("rst2_cnt", bus.split_cnt, 16'd0);
    step(1'b1, 32'h00100093, 32'h600, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h00510223, 32'h700 + 32'(i * 4), 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("sat_seq", sbus.split_cnt, 2'(sat(i + 1, 3)));
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hffff_fffc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
